// File: rtl/hilo_pkg.sv
// Package: hilo_pkg
// Shared definitions for the HiLo multiply/divide sequencer.
//   DATA_WIDTH   default operand width (HiLo is twice this)
//   OP_W         width of the op-code field
//   DIV_ZERO_LO  Lo value written when a divide has a zero divisor
//   hilo_op_t    op-code enum
//   hilo_state_t controller FSM state
//   op_class_t   coarse op grouping used by the controller
// Optional feature macro: HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
// Those four codes do not fit beside the six base ops in 3 bits, so the
// op field widens to 4 bits only when the feature is built in.
package hilo_pkg;

  localparam int DATA_WIDTH = 32;

`ifdef HILO_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  localparam logic [DATA_WIDTH-1:0] DIV_ZERO_LO = '1;

  // Codes 6 and 7 are deliberately left undefined.
  typedef enum logic [OP_W-1:0] {
    OP_MULT  = OP_W'(0),
    OP_MULTU = OP_W'(1),
    OP_DIV   = OP_W'(2),
    OP_DIVU  = OP_W'(3),
    OP_MTHI  = OP_W'(4),
    OP_MTLO  = OP_W'(5)
`ifdef HILO_MADD_EN
    ,
    OP_MADD  = OP_W'(8),
    OP_MADDU = OP_W'(9),
    OP_MSUB  = OP_W'(10),
    OP_MSUBU = OP_W'(11)
`endif
  } hilo_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_WRITE} hilo_state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_MUL, CLS_DIV, CLS_MOVE} op_class_t;

  function automatic op_class_t op_class(logic [OP_W-1:0] op);
    case (op)
      OP_MULT, OP_MULTU: return CLS_MUL;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return CLS_MUL;
`endif
      OP_DIV, OP_DIVU:   return CLS_DIV;
      OP_MTHI, OP_MTLO:  return CLS_MOVE;
      default:           return CLS_NONE;
    endcase
  endfunction

  function automatic logic op_signed(logic [OP_W-1:0] op);
    case (op)
      OP_MULT, OP_DIV: return 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MSUB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Interface: hilo_muldiv_ctrl_if
// Request/response bundle between decode (master) and the HiLo sequencer (slave).
//   Start, Op, OperandA, OperandB, HiLoIn, Flush      master -> slave
//   Busy, HiLoWriteEnable, HiLoWriteData, DivByZero   slave -> master
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_WIDTH = hilo_pkg::DATA_WIDTH
);
  logic                        Start;
  logic [hilo_pkg::OP_W-1:0]   Op;
  logic [DATA_WIDTH-1:0]       OperandA;
  logic [DATA_WIDTH-1:0]       OperandB;
  logic [2*DATA_WIDTH-1:0]     HiLoIn;
  logic                        Flush;
  logic                        Busy;
  logic                        HiLoWriteEnable;
  logic [2*DATA_WIDTH-1:0]     HiLoWriteData;
  logic                        DivByZero;

  modport master (
    output Start, Op, OperandA, OperandB, HiLoIn, Flush,
    input  Busy, HiLoWriteEnable, HiLoWriteData, DivByZero
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, HiLoIn, Flush,
    output Busy, HiLoWriteEnable, HiLoWriteData, DivByZero
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// Module: muldiv_iter_core
// Shared iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, BITS_PER_CYCLE bits retired per step.
//   clk       rising-edge clock
//   load      capture a, b and the mode; clears the upper accumulator half
//   step      advance one iteration
//   is_div    mode captured on load (1 = divide, 0 = multiply)
//   a, b      multiplier/multiplicand or dividend/divisor magnitudes
//   acc_next  accumulator after the pending step: {hi, lo} product or
//             {remainder, quotient}
module muldiv_iter_core #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] acc_next
);
  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_d, step_res;
  logic [W-1:0]   b_q, b_d;
  logic           is_div_q, is_div_d;
  logic [W:0]     part;

  // One iteration. The accumulator's low half holds the multiplier or the
  // not-yet-consumed dividend bits; the high half the partial sum/remainder.
  // NOTE: blocking assignments here are intentional; each inner loop pass
  // builds on the previous one within the same combinational evaluation.
  always_comb begin : step_logic
    // NOTE: every variable gets a default first so no latch is inferred.
    step_res = acc_q;
    part     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div_q) begin
        part = step_res[2*W-1:W-1];
        if (part >= {1'b0, b_q}) begin
          part     = part - {1'b0, b_q};
          step_res = {part[W-1:0], step_res[W-2:0], 1'b1};
        end else begin
          step_res = {part[W-1:0], step_res[W-2:0], 1'b0};
        end
      end else begin
        part     = {1'b0, step_res[2*W-1:W]} + (step_res[0] ? {1'b0, b_q} : '0);
        step_res = {part, step_res[W-1:1]};
      end
    end
  end

  always_comb begin : reg_next
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    if (load) begin
      acc_d    = {{W{1'b0}}, a};
      b_d      = b;
      is_div_d = is_div;
    end else if (step) begin
      acc_d = step_res;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded
  // before the controller reads them.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    b_q      <= b_d;
    is_div_q <= is_div_d;
  end

  assign acc_next = step_res;
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Module: hilo_muldiv_ctrl
// Multi-cycle multiply/divide sequencer that owns every write to HiLo.
//   Clock   rising-edge clock
//   Reset   synchronous, active-low
//   bus     hilo_muldiv_ctrl_if.slave: Start/Op/OperandA/OperandB/HiLoIn/Flush
//           in; Busy/HiLoWriteEnable/HiLoWriteData/DivByZero out
// MUL/DIV ops take N = DATA_WIDTH/BITS_PER_CYCLE iterations; the write strobe
// appears N+1 cycles after acceptance (1 cycle for MTHI/MTLO).
// BITS_PER_CYCLE must be 1, 2 or 4 and divide DATA_WIDTH.
// Optional feature macro: HILO_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate).
module hilo_muldiv_ctrl import hilo_pkg::*; #(
  parameter int DATA_WIDTH     = hilo_pkg::DATA_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  hilo_muldiv_ctrl_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int N     = W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);

  hilo_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, we_q, we_d, dz_q, dz_d;
  logic [2*W-1:0]   wdata_q, wdata_d;

  // Operand-side context captured at acceptance.
  logic [W-1:0]     opa_q, opa_d;
  logic             neg_lo_q, neg_lo_d;   // product sign / quotient sign
  logic             neg_hi_q, neg_hi_d;   // remainder sign
  logic             divz_q, divz_d;
`ifdef HILO_MADD_EN
  logic [OP_W-1:0]  op_q, op_d;
  logic [2*W-1:0]   hilo_q, hilo_d;
`endif

  op_class_t        acc_cls;
  logic             acc_sign_a, acc_sign_b;
  logic [W-1:0]     mag_a, mag_b;
  logic             core_load, core_step;
  logic [2*W-1:0]   core_res, result, prod;
  logic [W-1:0]     quo, rem;

  always_comb begin : accept_decode
    acc_cls    = op_class(bus.Op);
    acc_sign_a = op_signed(bus.Op) & bus.OperandA[W-1];
    acc_sign_b = op_signed(bus.Op) & bus.OperandB[W-1];
    mag_a      = acc_sign_a ? -bus.OperandA : bus.OperandA;
    mag_b      = acc_sign_b ? -bus.OperandB : bus.OperandB;
  end

  muldiv_iter_core #(
    .DATA_WIDTH     (W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk      (Clock),
    .load     (core_load),
    .step     (core_step),
    .is_div   (acc_cls == CLS_DIV),
    .a        (mag_a),
    .b        (mag_b),
    .acc_next (core_res)
  );

  // Sign fix-up and merge, applied to the final iteration's result as it is
  // registered for the WRITE cycle.
  always_comb begin : fixup
    prod = neg_lo_q ? -core_res : core_res;
    quo  = neg_lo_q ? -core_res[W-1:0] : core_res[W-1:0];
    rem  = neg_hi_q ? -core_res[2*W-1:W] : core_res[2*W-1:W];
    if (state_q == ST_DIV) begin
      result = divz_q ? {opa_q, W'(DIV_ZERO_LO)} : {rem, quo};
    end else begin
      result = prod;
`ifdef HILO_MADD_EN
      case (op_q)
        OP_MADD, OP_MADDU: result = hilo_q + prod;
        OP_MSUB, OP_MSUBU: result = hilo_q - prod;
        default:           result = prod;
      endcase
`endif
    end
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    dz_d      = 1'b0;
    wdata_d   = wdata_q;
    opa_d     = opa_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    divz_d    = divz_q;
`ifdef HILO_MADD_EN
    op_d      = op_q;
    hilo_d    = hilo_q;
`endif
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start && !bus.Flush) begin
          opa_d    = bus.OperandA;
          neg_lo_d = acc_sign_a ^ acc_sign_b;
          neg_hi_d = acc_sign_a;
          divz_d   = (acc_cls == CLS_DIV) && (bus.OperandB == '0);
          cnt_d    = '0;
`ifdef HILO_MADD_EN
          op_d     = bus.Op;
          hilo_d   = bus.HiLoIn;
`endif
          case (acc_cls)
            CLS_MUL: begin
              core_load = 1'b1;
              state_d   = ST_MUL;
            end
            CLS_DIV: begin
              core_load = 1'b1;
              state_d   = ST_DIV;
            end
            CLS_MOVE: begin
              state_d = ST_WRITE;
              we_d    = 1'b1;
              wdata_d = (bus.Op == OP_MTHI) ? {bus.OperandA, bus.HiLoIn[W-1:0]}
                                            : {bus.HiLoIn[2*W-1:W], bus.OperandA};
            end
            default: ;  // undefined op: accepted and dropped
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        core_step = 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          wdata_d = result;
          dz_d    = (state_q == ST_DIV) && divz_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (bus.Flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      dz_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      dz_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      dz_q    <= dz_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge Clock) begin
    opa_q    <= opa_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    divz_q   <= divz_d;
`ifdef HILO_MADD_EN
    op_q     <= op_d;
    hilo_q   <= hilo_d;
`endif
  end

  assign bus.Busy            = busy_q;
  assign bus.HiLoWriteData   = wdata_q;
  // A Flush arriving in the WRITE cycle itself still cancels the write.
  assign bus.HiLoWriteEnable = we_q & ~bus.Flush;
  assign bus.DivByZero       = dz_q & ~bus.Flush;
endmodule
